alu_wb_stage: RTL and testbench
===============================

Name: alu_wb_stage

Overview:
Writeback buffer directly downstream of the ALU. It captures each ALU result together with its destination register and write enable into a small in-order FIFO, then presents entries to the register-file write port through a valid/ready handshake. It also provides a forwarding lookup so the operand stage feeding the ALU can bypass results that are buffered but not yet written.

Parameters:
DATA_W, 32, result and register data width (matches the ALU result width)
REG_ADDR_W, 5, destination register index width
DEPTH, 2, FIFO entries; power of two, at least 2

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  ALU result presented
in_ready  output  1  stage can accept a result
in_result  input  DATA_W  ALU result
in_rd  input  REG_ADDR_W  destination register
in_we  input  1  instruction writes a register
out_valid  output  1  head entry valid toward the register file
out_ready  input  1  register file accepts the head entry
out_rd  output  REG_ADDR_W  head destination register
out_data  output  DATA_W  head data
count  output  $clog2(DEPTH)+1  current occupancy
fwd_rs  input  REG_ADDR_W  forwarding query register (ALU_WB_FWD_EN only)
fwd_hit  output  1  query matched a buffered entry (ALU_WB_FWD_EN only)
fwd_data  output  DATA_W  forwarded value (ALU_WB_FWD_EN only)

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset, effective immediately on rst_n low:
  - Pointers and count clear to 0; entry storage clears to 0.
  - out_valid=0, out_rd=0, out_data=0, fwd_hit=0, fwd_data=0, in_ready=1.
  - Reset mid-operation discards every buffered entry, and nothing is emitted afterward.
  - Handshakes are ignored while rst_n is low.
- Handshake:
  - A push occurs when in_valid && in_ready. A pop occurs when out_valid && out_ready.
  - in_ready = (count != DEPTH). It is a function of registered state only, with no combinational path from out_ready.
- Filtering: a push with in_we=0 or in_rd=0 is accepted (it consumes the handshake) but discarded. It is not enqueued and count does not change.
- Latency:
  - An entry pushed in cycle N is visible at out_valid/out_rd/out_data from cycle N+1.
  - There is no same-cycle bypass from input to output.
- Ordering: strict FIFO. Pointers wrap modulo DEPTH.
- Output when empty: out_valid=0, with out_rd and out_data driven to 0.
- Occupancy updates:
  - push only: count+1
  - pop only: count-1
  - simultaneous push and pop at 0 < count < DEPTH: count unchanged, head advances, tail advances
  - push when full: impossible, because in_ready=0
  - pop when empty: impossible, because out_valid=0
- Data: stored and emitted bit-exact, with no width conversion.

Optional Feature:
ALU_WB_FWD_EN
- Defined:
  - fwd_rs, fwd_hit and fwd_data exist.
  - The lookup is combinational over valid buffered entries. The newest entry with rd == fwd_rs wins.
  - fwd_rs == 0 never hits.
  - On a miss, fwd_hit=0 and fwd_data=0.
  - The current in_* input is not searched.
  - An entry popping this cycle still counts as a hit this cycle.
- Undefined: the three ports are absent and no comparison logic is built.

Test Plan:
- Reset, then push rd=5, data=0x00000007, we=1 in cycle N with out_ready=1 -> out_valid=1, out_rd=5, out_data=0x00000007 in cycle N+1; popped that cycle; out_valid=0 and count=0 in cycle N+2.
- out_ready=0; push A (rd=1, 0x11), B (rd=2, 0x22), C (rd=3, 0x33) -> A and B accepted, count=2, in_ready=0, C held; raise out_ready -> outputs A, B, C in order, with C accepted as soon as count<2.
- Push with in_we=0, then push with rd=0 and we=1 -> in_ready=1 throughout, count stays 0, out_valid never asserts.
- With count=1, push and pop in the same cycle -> count remains 1 and the next head equals the pushed entry.
- ALU_WB_FWD_EN, out_ready=0: buffer rd=3 with 0x10, then rd=3 with 0x20 -> fwd_rs=3 gives fwd_hit=1, fwd_data=0x20; fwd_rs=4 gives fwd_hit=0; fwd_rs=0 gives fwd_hit=0.
- Two entries buffered, rst_n pulsed low between clock edges -> out_valid=0, count=0, in_ready=1 immediately; no entry emitted after release.

Source files
------------

// File: rtl/alu_wb_stage.sv
// Writeback buffer between the ALU and the register-file write port: in-order FIFO
// with valid/ready on both sides. Define ALU_WB_FWD_EN to add the forwarding lookup.
module alu_wb_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int DEPTH      = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_result,
  input  logic [REG_ADDR_W-1:0]   in_rd,
  input  logic                    in_we,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [REG_ADDR_W-1:0]   out_rd,
  output logic [DATA_W-1:0]       out_data,
  output logic [$clog2(DEPTH):0]  count
`ifdef ALU_WB_FWD_EN
  ,
  input  logic [REG_ADDR_W-1:0]   fwd_rs,
  output logic                    fwd_hit,
  output logic [DATA_W-1:0]       fwd_data
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0]     data_q [DEPTH];
  logic [DATA_W-1:0]     data_d [DEPTH];
  logic [REG_ADDR_W-1:0] rd_q   [DEPTH];
  logic [REG_ADDR_W-1:0] rd_d   [DEPTH];
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  push_s, keep_s, pop_s;

  // Handshake flags and head presentation, all derived from registered state.
  always_comb begin
    in_ready  = (count_q != CNT_W'(DEPTH));
    out_valid = (count_q != {CNT_W{1'b0}});
    push_s    = in_valid && in_ready;
    keep_s    = push_s && in_we && (in_rd != {REG_ADDR_W{1'b0}});
    pop_s     = out_valid && out_ready;
    count     = count_q;
    if (out_valid) begin
      out_rd   = rd_q[head_q];
      out_data = data_q[head_q];
    end else begin
      out_rd   = {REG_ADDR_W{1'b0}};
      out_data = {DATA_W{1'b0}};
    end
  end

  // Next-state for storage, pointers and occupancy; filtered pushes leave all state alone.
  always_comb begin
    data_d = data_q;
    rd_d   = rd_q;
    if (keep_s) begin
      data_d[tail_q] = in_result;
      rd_d[tail_q]   = in_rd;
      tail_d         = tail_q + PTR_W'(1);
    end else begin
      tail_d = tail_q;
    end
    if (pop_s) begin
      head_d = head_q + PTR_W'(1);
    end else begin
      head_d = head_q;
    end
    case ({keep_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers with asynchronous clear of storage and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= {DATA_W{1'b0}};
        rd_q[i]   <= {REG_ADDR_W{1'b0}};
      end
      head_q  <= {PTR_W{1'b0}};
      tail_q  <= {PTR_W{1'b0}};
      count_q <= {CNT_W{1'b0}};
    end else begin
      data_q  <= data_d;
      rd_q    <= rd_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

`ifdef ALU_WB_FWD_EN
  // Walk oldest to newest so the newest matching entry overwrites earlier hits.
  always_comb begin
    logic [PTR_W-1:0] idx;
    fwd_hit  = 1'b0;
    fwd_data = {DATA_W{1'b0}};
    idx      = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (rd_q[idx] == fwd_rs) &&
          (fwd_rs != {REG_ADDR_W{1'b0}})) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end else begin
        fwd_hit  = fwd_hit;
        fwd_data = fwd_data;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_wb_stage.sv
// Self-checking bench for alu_wb_stage: queue-based reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_wb_stage;
  localparam int DATA_W = 32;
  localparam int RW     = 5;
  localparam int DEPTH  = 2;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0, in_we = 1'b0, out_ready = 1'b0;
  logic [DATA_W-1:0] in_result = '0;
  logic [RW-1:0]     in_rd = '0;
  logic              in_ready, out_valid;
  logic [RW-1:0]     out_rd;
  logic [DATA_W-1:0] out_data;
  logic [CW-1:0]     count;
  logic [RW-1:0]     fwd_rs = '0;
`ifdef ALU_WB_FWD_EN
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct { logic [RW-1:0] rd; logic [DATA_W-1:0] d; } ent_t;
  ent_t q[$];

  alu_wb_stage #(.DATA_W(DATA_W), .REG_ADDR_W(RW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_rd(in_rd), .in_we(in_we),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
    .out_data(out_data), .count(count)
`ifdef ALU_WB_FWD_EN
    , .fwd_rs(fwd_rs), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of kept writes; reset empties it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      int n;
      bit pop, push;
      n    = q.size();
      pop  = (n != 0) && out_ready;
      push = in_valid && (n != DEPTH);
      if (pop) void'(q.pop_front());
      if (push && in_we && in_rd != '0) q.push_back('{rd: in_rd, d: in_result});
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    logic              e_hit;
    logic [DATA_W-1:0] e_fd;
    chk("count", 64'(count), 64'(q.size()));
    chk("in_ready", 64'(in_ready), 64'(q.size() != DEPTH));
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("out_rd", 64'(out_rd), (q.size() != 0) ? 64'(q[0].rd) : 64'd0);
    chk("out_data", 64'(out_data), (q.size() != 0) ? 64'(q[0].d) : 64'd0);
    e_hit = 1'b0;
    e_fd  = '0;
    if (fwd_rs != '0) begin
      foreach (q[i]) if (q[i].rd == fwd_rs) begin e_hit = 1'b1; e_fd = q[i].d; end
    end
`ifdef ALU_WB_FWD_EN
    chk("fwd_hit", 64'(fwd_hit), 64'(e_hit));
    chk("fwd_data", 64'(fwd_data), 64'(e_fd));
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [RW-1:0] rd, input logic [DATA_W-1:0] d,
                       input logic we);
    in_valid = v; in_rd = rd; in_result = d; in_we = we;
  endtask

  initial begin
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Single entry, one-cycle latency, popped immediately.
    out_ready = 1'b1;
    drive(1'b1, 5'd5, 32'h7, 1'b1);
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b0);
    #1;
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_rd", 64'(out_rd), 64'd5);
    chk("t1_data", 64'(out_data), 64'h7);
    step();
    chk("t1_empty_valid", 64'(out_valid), 64'd0);
    chk("t1_empty_count", 64'(count), 64'd0);

    // Back-pressure: A, B fill the buffer, C waits.
    out_ready = 1'b0;
    drive(1'b1, 5'd1, 32'h11, 1'b1); step();
    drive(1'b1, 5'd2, 32'h22, 1'b1); step();
    drive(1'b1, 5'd3, 32'h33, 1'b1); #1;
    chk("t2_full_ready", 64'(in_ready), 64'd0);
    chk("t2_full_count", 64'(count), 64'd2);
    step();
    chk("t2_hold_head", 64'(out_data), 64'h11);
    out_ready = 1'b1;
    step();
    chk("t2_head_b", 64'(out_data), 64'h22);
    chk("t2_ready_again", 64'(in_ready), 64'd1);
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b0);
    #1;
    chk("t2_head_c", 64'(out_data), 64'h33);
    chk("t2_count_c", 64'(count), 64'd1);
    step();
    chk("t2_drained", 64'(count), 64'd0);

    // Filtered pushes are consumed but never buffered.
    drive(1'b1, 5'd7, 32'hDEAD, 1'b0); #1;
    chk("t3_ready_we0", 64'(in_ready), 64'd1);
    step();
    chk("t3_count_we0", 64'(count), 64'd0);
    drive(1'b1, 5'd0, 32'hBEEF, 1'b1); step();
    drive(1'b0, 5'd0, 32'h0, 1'b0);
    chk("t3_count_rd0", 64'(count), 64'd0);
    chk("t3_valid_rd0", 64'(out_valid), 64'd0);

    // Push and pop in the same cycle at count 1.
    out_ready = 1'b0;
    drive(1'b1, 5'd9, 32'h99, 1'b1); step();
    drive(1'b1, 5'd10, 32'hAA, 1'b1);
    out_ready = 1'b1;
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b0);
    #1;
    chk("t4_count", 64'(count), 64'd1);
    chk("t4_rd", 64'(out_rd), 64'd10);
    chk("t4_data", 64'(out_data), 64'hAA);
    step();

`ifdef ALU_WB_FWD_EN
    // Forwarding: newest match wins, miss and rs=0 return zero.
    out_ready = 1'b0;
    drive(1'b1, 5'd3, 32'h10, 1'b1); step();
    drive(1'b1, 5'd3, 32'h20, 1'b1); step();
    drive(1'b0, 5'd0, 32'h0, 1'b0);
    fwd_rs = 5'd3; #1;
    chk("t5_hit", 64'(fwd_hit), 64'd1);
    chk("t5_data", 64'(fwd_data), 64'h20);
    fwd_rs = 5'd4; #1;
    chk("t5_miss", 64'(fwd_hit), 64'd0);
    chk("t5_miss_data", 64'(fwd_data), 64'd0);
    fwd_rs = 5'd0; #1;
    chk("t5_rs0", 64'(fwd_hit), 64'd0);
    out_ready = 1'b1;
    step(); step();
`endif

    // Asynchronous reset with two entries buffered.
    out_ready = 1'b0;
    drive(1'b1, 5'd4, 32'h44, 1'b1); step();
    drive(1'b1, 5'd6, 32'h66, 1'b1); step();
    drive(1'b0, 5'd0, 32'h0, 1'b0);
    chk("t6_pre_count", 64'(count), 64'd2);
    rst_n = 1'b0; #1;
    chk("t6_rst_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_count", 64'(count), 64'd0);
    chk("t6_rst_ready", 64'(in_ready), 64'd1);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    step(); step();
    chk("t6_post_valid", 64'(out_valid), 64'd0);

    // Randomized traffic with frequent register collisions.
    for (int c = 0; c < 3000; c++) begin
      drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom(),
            1'($urandom_range(0, 7) != 0));
      out_ready = 1'($urandom_range(0, 2) != 0);
      fwd_rs    = 5'($urandom_range(0, 7));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
